// File: rtl/dm_access_ctrl.sv
// -----------------------------------------------------------------------------
// dm_access_ctrl
// Memory-stage initiator for a word-only data memory. Takes one load/store at a
// time (byte, half or word) from the pipeline. Sub-word stores become a
// read-modify-write because the memory only writes whole words. Sub-word loads
// are extracted and sign/zero-extended here. Misaligned or out-of-range
// accesses never touch the memory and complete with addr_err_o set.
//
// Ports
//   clk_i, rst_ni              clock (rising edge), async active-low reset
//   req_i .. req_pc_i          request from the pipeline, sampled only in IDLE
//   busy_o                     high in every state except IDLE
//   done_o, addr_err_o         one-cycle completion pulse and its error flag
//   rdata_o                    load result, holds until the next done
//   dm_addr_o .. dm_pc_o       word-aligned memory port plus trace PC
//   dm_rdata_i                 combinational read data for dm_addr_o
// -----------------------------------------------------------------------------
module dm_access_ctrl #(
  parameter int unsigned DM_WORDS = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [31:0] req_pc_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        addr_err_o,
  output logic [31:0] rdata_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_wdata_o,
  output logic        dm_we_o,
  output logic        dm_re_o,
  output logic [31:0] dm_pc_o,
  input  logic [31:0] dm_rdata_i
);

  localparam logic [1:0]  SZ_BYTE    = 2'b00;
  localparam logic [1:0]  SZ_HALF    = 2'b01;
  localparam logic [1:0]  SZ_WORD    = 2'b10;
  // One bit wider than the address so DM_WORDS*4 itself never wraps.
  localparam logic [32:0] ADDR_LIMIT = 33'(DM_WORDS) * 33'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Misalignment (size 11 counts as misaligned) or out-of-range address.
  function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr);
    logic misaligned;
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr[0];
      SZ_WORD: misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
    return misaligned || ({1'b0, addr} >= ADDR_LIMIT);
  endfunction

  // Select the addressed lane of a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic sgn);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] res;
    case (off)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: res = {{24{sgn & lane_b[7]}}, lane_b};
      SZ_HALF: res = {{16{sgn & lane_h[15]}}, lane_h};
      SZ_WORD: res = word;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Replace the addressed byte/half lane of the old word with new store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [15:0] wd,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] merged;
    merged = word;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'd0:    merged[7:0]   = wd[7:0];
          2'd1:    merged[15:8]  = wd[7:0];
          2'd2:    merged[23:16] = wd[7:0];
          default: merged[31:24] = wd[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off[1]) begin
          merged[31:16] = wd;
        end else begin
          merged[15:0] = wd;
        end
      end
      default: merged = word;
    endcase
    return merged;
  endfunction

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  off_q, off_d;
  // Only the low half of the store data is needed after accept: word stores
  // go straight to WR and take the full word from the request itself.
  logic [15:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic        dm_we_q, dm_we_d;
  logic        dm_re_q, dm_re_d;
  logic [31:0] dm_pc_q, dm_pc_d;
  logic        accept_s;
  logic        req_err_s;

  assign accept_s  = (state_q == ST_IDLE) && req_i;
  assign req_err_s = access_err(req_size_i, req_addr_i);

  // Next-state decode of the access sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!req_i) begin
          state_d = ST_IDLE;
        end else if (req_err_s) begin
          state_d = ST_RESP;
        end else if (req_we_i && (req_size_i == SZ_WORD)) begin
          state_d = ST_WR;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (we_q) begin
          state_d = ST_WR;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latches and registered outputs, all computed from the next state.
  always_comb begin
    we_d       = we_q;
    size_d     = size_q;
    signed_d   = signed_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    dm_addr_d  = dm_addr_q;
    dm_pc_d    = dm_pc_q;
    rdata_d    = rdata_q;
    dm_wdata_d = 32'h0000_0000;
    if (accept_s) begin
      we_d      = req_we_i;
      size_d    = req_size_i;
      signed_d  = req_signed_i;
      off_d     = req_addr_i[1:0];
      wdata_d   = req_wdata_i[15:0];
      dm_addr_d = {req_addr_i[31:2], 2'b00};
      dm_pc_d   = req_pc_i;
    end else begin
      we_d = we_q;
    end
    if (state_d == ST_WR) begin
      if (state_q == ST_IDLE) begin
        dm_wdata_d = req_wdata_i;
      end else begin
        dm_wdata_d = store_merge(dm_rdata_i, wdata_q, size_q, off_q);
      end
    end else begin
      dm_wdata_d = 32'h0000_0000;
    end
    // Only a load leaving RD produces data; stores and errors report zero.
    if (state_d == ST_RESP) begin
      if ((state_q == ST_RD) && !we_q) begin
        rdata_d = load_extract(dm_rdata_i, size_q, off_q, signed_q);
      end else begin
        rdata_d = 32'h0000_0000;
      end
    end else begin
      rdata_d = rdata_q;
    end
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_RESP);
    addr_err_d = (state_q == ST_IDLE) && (state_d == ST_RESP);
    dm_re_d    = (state_d == ST_RD);
    dm_we_d    = (state_d == ST_WR);
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      off_q      <= 2'b00;
      wdata_q    <= 16'h0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
      rdata_q    <= 32'h0000_0000;
      dm_addr_q  <= 32'h0000_0000;
      dm_wdata_q <= 32'h0000_0000;
      dm_we_q    <= 1'b0;
      dm_re_q    <= 1'b0;
      dm_pc_q    <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      addr_err_q <= addr_err_d;
      rdata_q    <= rdata_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      dm_we_q    <= dm_we_d;
      dm_re_q    <= dm_re_d;
      dm_pc_q    <= dm_pc_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign addr_err_o = addr_err_q;
  assign rdata_o    = rdata_q;
  assign dm_addr_o  = dm_addr_q;
  assign dm_wdata_o = dm_wdata_q;
  assign dm_we_o    = dm_we_q;
  assign dm_re_o    = dm_re_q;
  assign dm_pc_o    = dm_pc_q;

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
Memory-stage initiator that drives the word-only data memory port on behalf of the pipeline.
- Accepts one load/store request at a time: byte, halfword or word.
- Performs read-modify-write for sub-word stores; the data memory writes only whole words.
- Extracts and sign/zero-extends sub-word load data.
- Stalls the pipeline via `busy` and flags misaligned or out-of-range accesses.

Parameters:
- DM_WORDS, 1024, number of 32-bit words in the data memory; byte addresses >= DM_WORDS*4 are out of range.

Ports:
- clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- req  in  1  request valid; sampled only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as a misaligned access
- req_signed  in  1  load sign-extend (1) or zero-extend (0)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_pc  in  32  PC of the requesting instruction
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: request complete
- addr_err  out  1  valid with done: access was misaligned or out of range
- rdata  out  32  load result, valid with done; holds until the next done
- dm_addr  out  32  latched address with bits [1:0] forced to 0
- dm_wdata  out  32  full word to write
- dm_we  out  1  memory write strobe
- dm_re  out  1  memory read strobe
- dm_pc  out  32  latched req_pc, for the memory's write trace
- dm_rdata  in  32  combinational memory read data for dm_addr

Behaviour:
- Reset low, asynchronously:
  - state = IDLE.
  - All outputs are 0; all latches are 0.
  - Any in-flight store is abandoned; dm_we never pulses during or after reset.
- FSM states: IDLE, RD, WR, RESP.
- IDLE:
  - If req=1, latch addr, size, we, signed, wdata and pc.
  - Error check:
    - size 11 → error.
    - half with addr[0]≠0 → error.
    - word with addr[1:0]≠0 → error.
    - addr ≥ DM_WORDS*4 → error.
  - Next state:
    - error → RESP with addr_err.
    - load → RD.
    - word store → WR.
    - byte/half store → RD.
- RD:
  - dm_re=1.
  - Capture dm_rdata into an internal buffer at the clock edge.
  - Next state: store → WR; load → RESP.
- WR:
  - dm_we=1 for exactly this cycle.
  - dm_wdata:
    - word: latched wdata.
    - half: buffer with halfword lane addr[1] replaced by wdata[15:0].
    - byte: buffer with byte lane addr[1:0] (bits 8k+7:8k) replaced by wdata[7:0].
  - Next state → RESP.
- RESP:
  - done=1.
  - addr_err is registered from the IDLE check.
  - rdata is updated on entry into RESP:
    - loads: extracted, extended lane; byte/half lane selection is the same as for stores.
    - stores and errors: rdata = 0.
  - Next state → IDLE.
  - req is not accepted in RESP; the pipeline holds req while busy.
- Latency from the accepting edge to done:
  - error: 1 cycle.
  - load: 2 cycles.
  - word store: 2 cycles.
  - byte/half store: 3 cycles.
- An error never asserts dm_re or dm_we.
- dm_addr and dm_pc stay stable from accept until return to IDLE.
- Outside RD, dm_re=0; outside WR, dm_we=0.
- Inputs changing while busy have no effect.

Test Plan:
- Word store then load:
  - Store addr 0x10, data 0xDEADBEEF → WR cycle with dm_we=1, dm_addr=0x10, dm_wdata=0xDEADBEEF; done 2 cycles after accept.
  - Load word 0x10 → rdata=0xDEADBEEF, addr_err=0.
- Byte store RMW:
  - Mem[0x20]=0x11223344; sb 0xAB to 0x22 → RD then WR with dm_wdata=0x11AB3344; done 3 cycles after accept.
- Loads of byte/half with extension, mem[0x30]=0x80F07F01:
  - lb 0x33 → 0xFFFFFF80.
  - lbu 0x33 → 0x00000080.
  - lh 0x30 → 0x00007F01.
  - lhu 0x32 → 0x000080F0.
- Errors:
  - lw 0x06 → done+addr_err 1 cycle after accept, rdata=0, dm_re/dm_we never high.
  - sh 0x41 → same response.
  - sw 0x1000 with DM_WORDS=1024 → same response.
- Reset mid-operation:
  - Assert Reset low during RD of an sb → all outputs 0 immediately.
  - No dm_we pulse occurs.
  - After release, state is IDLE and a new request is accepted.
- Busy/hold:
  - Toggle req_addr and req_wdata while busy → response reflects only the latched values.
  - busy is low exactly one cycle after done.
